// File: rtl/box_draw_control.sv
// Frame sequencer for a single vertically-moving box: erase old position, move, redraw.
// Optional erase pass is built in when BOX_DRAW_CONTROL_ERASE_EN is defined.
module box_draw_control #(
    parameter int         BOX_X  = 2,
    parameter int         BOX_W  = 4,
    parameter int         BOX_H  = 4,
    parameter int         Y_MAX  = 119,
    parameter int         Y_INIT = 58,
    parameter logic [2:0] COLOUR = 3'b111
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       move_up,
    input  logic       move_down,
    output logic       busy,
    output logic       plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       done,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ERASE = 3'd1,
        MOVE  = 3'd2,
        DRAW  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] CX_LAST = 4'(BOX_W - 1);
    localparam logic [3:0] CY_LAST = 4'(BOX_H - 1);
    localparam logic [7:0] X_BASE  = 8'(BOX_X);
    localparam logic [6:0] Y_LIMIT = 7'(Y_MAX - BOX_H + 1);
    localparam logic [6:0] Y_START = 7'(Y_INIT);

    state_t     state;
    logic [6:0] box_y;
    logic [3:0] cx;
    logic [3:0] cy;

    logic [3:0] nx_cx;
    logic [3:0] nx_cy;
    logic       scan_last;
    logic [6:0] moved_y;

    assign state_dbg = state;
    assign scan_last = (cx == CX_LAST) && (cy == CY_LAST);

    // Row-major scan: column counter advances every cycle, row on column wrap.
    always_comb begin
        nx_cx = cx + 4'd1;
        nx_cy = cy;
        if (cx == CX_LAST) begin
            nx_cx = 4'd0;
            nx_cy = cy + 4'd1;
        end
    end

    // Conflicting or absent requests, and requests past a screen edge, hold position.
    always_comb begin
        moved_y = box_y;
        if (move_up && !move_down && box_y != 7'd0)
            moved_y = box_y - 7'd1;
        else if (move_down && !move_up && box_y < Y_LIMIT)
            moved_y = box_y + 7'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            box_y  <= Y_START;
            cx     <= 4'd0;
            cy     <= 4'd0;
            busy   <= 1'b0;
            plot   <= 1'b0;
            x      <= 8'd0;
            y      <= 7'd0;
            colour <= 3'd0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (frame_tick) begin
                        busy <= 1'b1;
                        cx   <= 4'd0;
                        cy   <= 4'd0;
`ifdef BOX_DRAW_CONTROL_ERASE_EN
                        state  <= ERASE;
                        plot   <= 1'b1;
                        colour <= 3'd0;
                        x      <= X_BASE;
                        y      <= box_y;
`else
                        state  <= MOVE;
`endif
                    end
                end
`ifdef BOX_DRAW_CONTROL_ERASE_EN
                ERASE: begin
                    if (scan_last) begin
                        state <= MOVE;
                        plot  <= 1'b0;
                        cx    <= 4'd0;
                        cy    <= 4'd0;
                    end else begin
                        cx <= nx_cx;
                        cy <= nx_cy;
                        x  <= X_BASE + {4'd0, nx_cx};
                        y  <= box_y + {3'd0, nx_cy};
                    end
                end
`endif
                MOVE: begin
                    // The first draw pixel already uses the updated row.
                    box_y  <= moved_y;
                    state  <= DRAW;
                    plot   <= 1'b1;
                    colour <= COLOUR;
                    x      <= X_BASE;
                    y      <= moved_y;
                    cx     <= 4'd0;
                    cy     <= 4'd0;
                end
                DRAW: begin
                    if (scan_last) begin
                        state <= DONE;
                        plot  <= 1'b0;
                        done  <= 1'b1;
                        cx    <= 4'd0;
                        cy    <= 4'd0;
                    end else begin
                        cx <= nx_cx;
                        cy <= nx_cy;
                        x  <= X_BASE + {4'd0, nx_cx};
                        y  <= box_y + {3'd0, nx_cy};
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    plot  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/box_draw_control.md
BOX_DRAW_CONTROL -- requirements
Module: box_draw_control

Interface
REQ-001 Parameter BOX_X, default 2, fixed left column of the box.
REQ-002 Parameter BOX_W, default 4, box width in pixels (1..16).
REQ-003 Parameter BOX_H, default 4, box height in pixels (1..16).
REQ-004 Parameter Y_MAX, default 119, last screen row.
REQ-005 Parameter Y_INIT, default 58, box top row after reset.
REQ-006 Parameter COLOUR, default 3'b111, draw colour.
REQ-007 clk  input  1  system clock; all state changes on its rising edge.
REQ-008 resetn  input  1  asynchronous, active-low reset.
REQ-009 frame_tick  input  1  single-cycle frame-start pulse.
REQ-010 move_up  input  1  level; request box_y decrement.
REQ-011 move_down  input  1  level; request box_y increment.
REQ-012 busy  output  1  high while a frame sequence is in progress.
REQ-013 plot  output  1  pixel write strobe to the VGA adapter.
REQ-014 x  output  8  pixel column.
REQ-015 y  output  7  pixel row.
REQ-016 colour  output  3  pixel colour.
REQ-017 done  output  1  single-cycle pulse at end of sequence.

Function
REQ-018 The FSM SHALL have states IDLE, ERASE, MOVE, DRAW and DONE; all outputs SHALL be registered.
REQ-019 IDLE: busy=0, plot=0; frame_tick sampled high SHALL move to ERASE.
REQ-020 ERASE: exactly BOX_W*BOX_H consecutive cycles, plot=1, colour=0, row-major scan (column counter fastest), x=BOX_X+cx, y=box_y+cy.
REQ-021 After the last ERASE pixel, the FSM SHALL spend exactly one cycle in MOVE with plot=0.
REQ-022 MOVE: up-only and box_y>0 -> box_y-1; down-only and box_y<Y_MAX-BOX_H+1 -> box_y+1; both, neither, or at limit -> hold.
REQ-023 DRAW: same scan and cycle count as ERASE using the updated box_y, colour=COLOUR.
REQ-024 DONE: one cycle, done=1, plot=0, then IDLE.
REQ-025 busy SHALL be high in every non-IDLE state.
REQ-026 frame_tick while busy SHALL be ignored, not queued.
REQ-027 Scan counters SHALL be 4 bits each; x and y are sums truncated to port width; parameters guarantee BOX_X+BOX_W<=160 and no overflow.
REQ-028 Default timing, tick sampled at edge 0: ERASE cycles 1-16, MOVE 17, DRAW 18-33, DONE 34.

Reset
REQ-029 resetn low SHALL immediately force IDLE, box_y=Y_INIT, counters=0, and busy, plot, x, y, colour, done=0.
REQ-030 Reset mid-sequence SHALL abort it; no further plot until the next frame_tick after release.

Configuration
REQ-031 Macro BOX_DRAW_CONTROL_ERASE_EN defined: ERASE state present as above.
REQ-032 Macro undefined: ERASE omitted; IDLE goes directly to MOVE; default timing MOVE cycle 1, DRAW 2-17, DONE 18.

Verification
REQ-033 Reset asserted -> busy=0, plot=0, x=0, y=0, colour=0, done=0; first frame draws at rows 58-61.
REQ-034 Erase enabled, defaults, frame_tick, no buttons -> 16 plots colour 0 at x 2-5 y 58-61, one gap cycle, 16 plots colour 7 same area, done at cycle 34.
REQ-035 box_y=0, move_up held -> draw rows 0-3; box_y=115, move_down -> draw rows 116-119; next frame with move_down -> rows stay 116-119.
REQ-036 move_up and move_down both high -> box_y unchanged; frame_tick pulsed during DRAW -> no second sequence, busy falls after DONE.
REQ-037 resetn low at DRAW cycle 20 -> plot=0 at once, next frame draws at rows 58-61.
REQ-038 Macro undefined, frame_tick -> first plot colour 7 at cycle 2, no colour-0 plots, done at cycle 18.
